prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Receive-side partner of the on-chip 4-bit Galois LFSR generator: samples the generator state word, self-synchronises to it, then checks every later sample against a locally predicted sequence.
- Reports lock status and a saturating error count, so the bench and debug logic can confirm that the pseudo-random stream driving predictor-perturbation logic is intact.
- Sits beside the generator in the branch-predictor test harness.

Parameters:
- WIDTH, 4, LFSR state width in bits.
- POLY, 4'b0011, Galois feedback mask. The mask is XORed into the left-shifted state when the old MSB is 1.
- LOCK_CNT, 4, consecutive correct predictions needed to declare lock (>=1).
- LOSS_CNT, 3, consecutive mispredictions while locked that cause return to hunt (>=1).
- ERR_W, 16, error counter width.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, in_state carries a new generator sample this cycle.
- in_state, input, WIDTH, observed generator state.
- clear_err, input, 1, synchronous clear of err_count.
- locked, output, 1, checker is in LOCKED.
- err_pulse, output, 1, one-cycle pulse per mismatch detected while LOCKED.
- err_count, output, ERR_W, saturating mismatch count.
- period_count, output, WIDTH+1, measured sequence period (feature only; 0 otherwise).
- period_ok, output, 1, period_count equals 2^WIDTH-1 (feature only; 0 otherwise).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Step function: step(s) = {s[W-2:0],1'b0} ^ (s[W-1] ? POLY : 0).
  - With the defaults, seed 1 gives 1,2,4,8,3,6,12,11,5,10,7,14,15,13,9,1 (period 15).
- Reset values:
  - Outputs: locked=0, err_pulse=0, err_count=0, period_count=0, period_ok=0.
  - Internal: state=HUNT, pred=0, match_cnt=0, miss_cnt=0.
- All outputs are registered, with 1-cycle latency from the sample edge. Nothing advances while in_valid=0, and gaps of any length are transparent.
- HUNT state:
  - Valid nonzero sample: pred<=step(sample), match_cnt<=0, go to VERIFY.
  - Zero sample (lockup state): ignored, stay in HUNT.
- VERIFY state:
  - sample==pred: pred<=step(pred), match_cnt++.
  - On the LOCK_CNT-th consecutive match: go to LOCKED, locked=1 on the next cycle.
  - Mismatch with nonzero sample: reseed, pred<=step(sample), match_cnt<=0.
  - Mismatch with zero sample: go to HUNT.
  - No errors are counted in VERIFY.
- LOCKED state:
  - Match: miss_cnt<=0, pred<=step(pred).
  - Mismatch: err_pulse=1 for one cycle, err_count+1 (saturates at all-ones), miss_cnt++.
    - The checker flywheels on pred<=step(pred) and does not resync to the bad sample.
  - On the LOSS_CNT-th consecutive mismatch: go to HUNT, locked=0 the next cycle, counters cleared.
    - err_count is retained.
- Simultaneous clear_err and error: clear wins, err_count=0, err_pulse still asserts.
- Reset mid-stream: immediate return to reset values. Relock needs 1+LOCK_CNT valid samples.

Optional Feature:
- Macro PRBS_CHK_PERIOD_EN.
- Defined:
  - On entry to LOCKED, capture the reference state ref<=pred and start a period counter counting valid matched samples.
  - When a matched sample equals ref again: period_count<=counter, period_ok<=(counter==2^WIDTH-1), counter restarts.
  - A mismatch aborts the measurement until the next entry to LOCKED. period_ok holds its last value.
- Undefined: no counter logic; period_count and period_ok are tied to 0.

Decomposition:
- Package prbs_pkg:
  - state enum {HUNT, VERIFY, LOCKED}.
  - Function lfsr_step(state, poly).
  - Default POLY and WIDTH constants, shared with the generator.
- Sub-module prbs_predictor holds pred with load/advance controls and exposes step output and match flag. The FSM, counters and optional period logic stay in prbs_checker.

Test Plan:
- Lock: reset, then feed 1,2,4,8,3 valid back-to-back -> locked=1 the cycle after sample 3; err_count=0.
- Single error: locked stream ...,3,6,12, then 10 instead of 11, then 5 -> one err_pulse, err_count=1, locked stays 1, sample 5 matches.
- Loss/relock: three consecutive wrong samples while locked -> locked=0 after the 3rd, err_count=3. Then clean stream from 7 -> relock after 5 samples, err_count still 3.
- Zero and gaps: in_state=0 for 10 valid samples in HUNT -> locked stays 0. Locked stream with in_valid low 3 cycles between samples -> no errors.
- Saturation/clear: preload near all-ones via repeated errors with ERR_W=4 -> err_count stops at 15. clear_err coincident with an error -> err_count=0, err_pulse=1.
- PRBS_CHK_PERIOD_EN: locked clean stream for 40 samples -> period_count=15, period_ok=1. With the macro undefined, both read 0.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the 4-bit Galois LFSR generator and its checker.
// Holds the default width and feedback mask, the checker FSM state type and
// a width-generic Galois step function used by both sides.
package prbs_pkg;

  localparam int PRBS_WIDTH = 4;
  localparam logic [PRBS_WIDTH-1:0] PRBS_POLY = 4'b0011;

  // Widest LFSR the step helper supports.
  localparam int LFSR_MAX_W = 32;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_e;

  // Galois step: shift left, and fold the feedback mask in when the old MSB
  // was set. The MSB is located through the width mask so that no variable
  // bit index is needed.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] poly,
    input int unsigned           width
  );
    logic [LFSR_MAX_W-1:0] mask;
    logic [LFSR_MAX_W-1:0] msb_bit;
    logic [LFSR_MAX_W-1:0] nxt;
    mask    = {LFSR_MAX_W{1'b1}} >> (LFSR_MAX_W - width);
    msb_bit = mask ^ (mask >> 1);
    nxt     = (state << 1) & mask;
    if (|(state & msb_bit)) begin
      nxt = nxt ^ (poly & mask);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/prbs_checker_predictor.sv
// Local copy of the generator: holds the predicted next sample, can be
// reseeded from an observed sample or advanced by one LFSR step, and flags
// whether the current sample equals the prediction.
module prbs_predictor
  import prbs_pkg::*;
#(
  parameter int              WIDTH = PRBS_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = PRBS_POLY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] sample,
  output logic             match
);

  logic [WIDTH-1:0] pred_q;
  logic [WIDTH-1:0] pred_d;
  logic [WIDTH-1:0] sample_step;
  logic [WIDTH-1:0] pred_step;

  assign sample_step = WIDTH'(lfsr_step(LFSR_MAX_W'(sample), LFSR_MAX_W'(POLY), WIDTH));
  assign pred_step   = WIDTH'(lfsr_step(LFSR_MAX_W'(pred_q), LFSR_MAX_W'(POLY), WIDTH));
  assign match       = (sample == pred_q);

  // Reseed from the sample takes priority over flywheeling on the prediction.
  always_comb begin
    pred_d = pred_q;
    if (load) begin
      pred_d = sample_step;
    end else if (advance) begin
      pred_d = pred_step;
    end
  end

  // Prediction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_q <= '0;
    end else begin
      pred_q <= pred_d;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the Galois LFSR generator state stream.
// Hunts for a nonzero sample, verifies LOCK_CNT consecutive predictions,
// then counts mismatches while locked and drops back to hunting after
// LOSS_CNT consecutive misses. Optional sequence-period measurement is
// enabled by defining PRBS_CHK_PERIOD_EN; otherwise period outputs read 0.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int               WIDTH    = PRBS_WIDTH,
  parameter logic [WIDTH-1:0] POLY     = PRBS_POLY,
  parameter int               LOCK_CNT = 4,
  parameter int               LOSS_CNT = 3,
  parameter int               ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_state,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH:0]   period_count,
  output logic             period_ok
);

  localparam int MCW = $clog2(LOCK_CNT + 1);
  localparam int LCW = $clog2(LOSS_CNT + 1);
  localparam logic [MCW-1:0] LOCK_LAST = MCW'(LOCK_CNT);
  localparam logic [LCW-1:0] LOSS_LAST = LCW'(LOSS_CNT);

  prbs_state_e      state_q, state_d;
  logic [MCW-1:0]   match_cnt_q, match_cnt_d, match_inc;
  logic [LCW-1:0]   miss_cnt_q, miss_cnt_d, miss_inc;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             err_pulse_q, err_pulse_d;
  logic             locked_q, locked_d;
  logic             pred_load, pred_advance, pred_match;

  prbs_predictor #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_pred (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pred_load),
    .advance (pred_advance),
    .sample  (in_state),
    .match   (pred_match)
  );

  // FSM, lock/loss counters and error accounting; all moves happen only on
  // valid samples so idle gaps are invisible to the checker.
  always_comb begin
    state_d      = state_q;
    match_cnt_d  = match_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    err_count_d  = err_count_q;
    err_pulse_d  = 1'b0;
    pred_load    = 1'b0;
    pred_advance = 1'b0;
    match_inc    = match_cnt_q + 1'b1;
    miss_inc     = miss_cnt_q + 1'b1;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_state != '0) begin
            pred_load   = 1'b1;
            match_cnt_d = '0;
            state_d     = VERIFY;
          end
        end
        VERIFY: begin
          if (pred_match) begin
            pred_advance = 1'b1;
            if (match_inc == LOCK_LAST) begin
              state_d     = LOCKED;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
            end else begin
              match_cnt_d = match_inc;
            end
          end else if (in_state != '0) begin
            pred_load   = 1'b1;
            match_cnt_d = '0;
          end else begin
            match_cnt_d = '0;
            state_d     = HUNT;
          end
        end
        LOCKED: begin
          pred_advance = 1'b1;
          if (pred_match) begin
            miss_cnt_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + 1'b1;
            end
            if (miss_inc == LOSS_LAST) begin
              state_d     = HUNT;
              miss_cnt_d  = '0;
              match_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_inc;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
    if (clear_err) begin
      err_count_d = '0;
    end
    locked_d = (state_d == LOCKED);
  end

  // Core state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

`ifdef PRBS_CHK_PERIOD_EN
  localparam logic [WIDTH:0] FULL_PERIOD = {1'b0, {WIDTH{1'b1}}};

  logic [WIDTH-1:0] ref_state_q, ref_state_d;
  logic [WIDTH:0]   pcnt_q, pcnt_d, pcnt_inc;
  logic             pact_q, pact_d;
  logic [WIDTH:0]   period_count_q, period_count_d;
  logic             period_ok_q, period_ok_d;
  logic             enter_lock;

  // Period measurement: the sample that completed lock is the reference;
  // count matched samples until it reappears. Any miss abandons the run
  // until lock is next acquired.
  always_comb begin
    ref_state_d    = ref_state_q;
    pcnt_d         = pcnt_q;
    pact_d         = pact_q;
    period_count_d = period_count_q;
    period_ok_d    = period_ok_q;
    enter_lock     = in_valid && (state_q == VERIFY) && (state_d == LOCKED);
    pcnt_inc       = (pcnt_q == '1) ? pcnt_q : pcnt_q + 1'b1;
    if (enter_lock) begin
      ref_state_d = in_state;
      pcnt_d      = '0;
      pact_d      = 1'b1;
    end else if (in_valid && (state_q == LOCKED)) begin
      if (!pred_match) begin
        pact_d = 1'b0;
      end else if (pact_q) begin
        if (in_state == ref_state_q) begin
          period_count_d = pcnt_inc;
          period_ok_d    = (pcnt_inc == FULL_PERIOD);
          pcnt_d         = '0;
        end else begin
          pcnt_d = pcnt_inc;
        end
      end
    end
  end

  // Period measurement registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_state_q    <= '0;
      pcnt_q         <= '0;
      pact_q         <= 1'b0;
      period_count_q <= '0;
      period_ok_q    <= 1'b0;
    end else begin
      ref_state_q    <= ref_state_d;
      pcnt_q         <= pcnt_d;
      pact_q         <= pact_d;
      period_count_q <= period_count_d;
      period_ok_q    <= period_ok_d;
    end
  end

  assign period_count = period_count_q;
  assign period_ok    = period_ok_q;
`else
  assign period_count = '0;
  assign period_ok    = 1'b0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker. A default instance and an ERR_W=4
// instance see the same stimulus; a table-driven sequence model pushes the
// expected outputs of every driven cycle to a scoreboard queue, which is
// popped and compared after the following clock edge.
`timescale 1ns/1ps
module tb_prbs_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_state;
  logic       clear_err;

  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic [4:0]  period_count;
  logic        period_ok;

  logic        s_locked, s_err_pulse;
  logic [3:0]  s_err_count;
  logic [4:0]  s_period_count;
  logic        s_period_ok;

  int errorCount = 0;
  int checkCount = 0;

`ifdef PRBS_CHK_PERIOD_EN
  localparam int EXP_PC  = 15;
  localparam int EXP_POK = 1;
`else
  localparam int EXP_PC  = 0;
  localparam int EXP_POK = 0;
`endif

  // Free-running clock.
  always #5 clk = ~clk;

  prbs_checker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_state     (in_state),
    .clear_err    (clear_err),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .period_count (period_count),
    .period_ok    (period_ok)
  );

  prbs_checker #(.ERR_W(4)) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_state     (in_state),
    .clear_err    (clear_err),
    .locked       (s_locked),
    .err_pulse    (s_err_pulse),
    .err_count    (s_err_count),
    .period_count (s_period_count),
    .period_ok    (s_period_ok)
  );

  typedef struct {
    logic        lk;
    logic        pulse;
    logic [15:0] err;
    logic [3:0]  err4;
    logic [4:0]  pc;
    logic        pok;
  } exp_t;

  exp_t sb[$];

  // Successor table built from the documented seed-1 sequence.
  logic [3:0] nxtTab [16];
  int seqList [15] = '{1, 2, 4, 8, 3, 6, 12, 11, 5, 10, 7, 14, 15, 13, 9};

  // Model state: 0 hunt, 1 verify, 2 locked.
  int         mState, mMatch, mMiss, mErr, mErr4, mPc, mPok, mPcnt, mPact;
  logic [3:0] mPred, mRef;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mState = 0; mMatch = 0; mMiss = 0; mErr = 0; mErr4 = 0;
    mPc = 0; mPok = 0; mPcnt = 0; mPact = 0; mPred = 4'd0; mRef = 4'd0;
  endtask

  task automatic modelStep(input logic v, input logic [3:0] s, input logic clr);
    exp_t e;
    logic pulse;
    pulse = 1'b0;
    if (v) begin
      if (mState == 0) begin
        if (s != 4'd0) begin
          mPred = nxtTab[s]; mMatch = 0; mState = 1;
        end
      end else if (mState == 1) begin
        if (s == mPred) begin
          mPred = nxtTab[mPred];
          mMatch++;
          if (mMatch == 4) begin
            mState = 2; mMatch = 0; mMiss = 0;
            mRef = s; mPcnt = 0; mPact = 1;
          end
        end else if (s != 4'd0) begin
          mPred = nxtTab[s]; mMatch = 0;
        end else begin
          mState = 0; mMatch = 0;
        end
      end else begin
        if (s == mPred) begin
          mMiss = 0;
          if (mPact == 1) begin
            mPcnt++;
            if (s == mRef) begin
              mPc = mPcnt; mPok = (mPcnt == 15) ? 1 : 0; mPcnt = 0;
            end
          end
        end else begin
          pulse = 1'b1;
          if (mErr != 65535) mErr++;
          if (mErr4 != 15) mErr4++;
          mMiss++;
          mPact = 0;
          if (mMiss == 3) begin
            mState = 0; mMiss = 0; mMatch = 0;
          end
        end
        mPred = nxtTab[mPred];
      end
    end
    if (clr) begin
      mErr = 0; mErr4 = 0;
    end
    e.lk    = (mState == 2);
    e.pulse = pulse;
    e.err   = 16'(mErr);
    e.err4  = 4'(mErr4);
`ifdef PRBS_CHK_PERIOD_EN
    e.pc    = 5'(mPc);
    e.pok   = (mPok == 1);
`else
    e.pc    = 5'd0;
    e.pok   = 1'b0;
`endif
    sb.push_back(e);
  endtask

  // Drive one cycle, record its expectation, and compare after the edge.
  task automatic applyStimulus(input logic v, input logic [3:0] s, input logic clr);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_state  = s;
    clear_err = clr;
    modelStep(v, s, clr);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkOutput("locked",          32'(locked),         32'(e.lk));
      checkOutput("err_pulse",       32'(err_pulse),      32'(e.pulse));
      checkOutput("err_count",       32'(err_count),      32'(e.err));
      checkOutput("period_count",    32'(period_count),   32'(e.pc));
      checkOutput("period_ok",       32'(period_ok),      32'(e.pok));
      checkOutput("sat_locked",      32'(s_locked),       32'(e.lk));
      checkOutput("sat_err_pulse",   32'(s_err_pulse),    32'(e.pulse));
      checkOutput("sat_err_count",   32'(s_err_count),    32'(e.err4));
      checkOutput("sat_period_count",32'(s_period_count), 32'(e.pc));
      checkOutput("sat_period_ok",   32'(s_period_ok),    32'(e.pok));
    end
  endtask

  // Asynchronous reset, checked before any clock edge can act on it.
  task automatic doReset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    clear_err = 1'b0;
    #1;
    checkOutput("rst_locked",       32'(locked),       32'd0);
    checkOutput("rst_err_pulse",    32'(err_pulse),    32'd0);
    checkOutput("rst_err_count",    32'(err_count),    32'd0);
    checkOutput("rst_period_count", 32'(period_count), 32'd0);
    checkOutput("rst_period_ok",    32'(period_ok),    32'd0);
    checkOutput("rst_sat_err",      32'(s_err_count),  32'd0);
    modelReset();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Feed n consecutive sequence values from start, with idle gaps between.
  task automatic feedRun(input logic [3:0] start, input int n, input int gap);
    logic [3:0] v;
    v = start;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, v, 1'b0);
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      v = nxtTab[v];
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nxtTab[0] = 4'd0;
    for (int i = 0; i < 15; i++) nxtTab[seqList[i]] = 4'(seqList[(i + 1) % 15]);
    rst_n = 1'b0; in_valid = 1'b0; in_state = 4'd0; clear_err = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    doReset();

    $display("[TB] lock acquisition");
    feedRun(4'd1, 5, 0);
    checkOutput("lock_after_3", 32'(locked), 32'd1);
    checkOutput("lock_err0", 32'(err_count), 32'd0);

    $display("[TB] single error");
    feedRun(4'd6, 2, 0);
    applyStimulus(1'b1, 4'd10, 1'b0);
    checkOutput("single_pulse", 32'(err_pulse), 32'd1);
    applyStimulus(1'b1, 4'd5, 1'b0);
    checkOutput("single_err1", 32'(err_count), 32'd1);
    checkOutput("single_locked", 32'(locked), 32'd1);
    checkOutput("single_nopulse", 32'(err_pulse), 32'd0);

    $display("[TB] loss and relock");
    doReset();
    feedRun(4'd1, 5, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, mPred ^ 4'h5, 1'b0);
    checkOutput("loss_unlocked", 32'(locked), 32'd0);
    checkOutput("loss_err3", 32'(err_count), 32'd3);
    feedRun(4'd7, 4, 0);
    checkOutput("relock_not_yet", 32'(locked), 32'd0);
    feedRun(4'd9, 1, 0);
    checkOutput("relock", 32'(locked), 32'd1);
    checkOutput("relock_err3", 32'(err_count), 32'd3);

    $display("[TB] zeros and gaps");
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 4'd0, 1'b0);
    checkOutput("zero_hunt", 32'(locked), 32'd0);
    feedRun(4'd1, 12, 3);
    checkOutput("gap_locked", 32'(locked), 32'd1);
    checkOutput("gap_err0", 32'(err_count), 32'd0);

    $display("[TB] clear coincident with error");
    applyStimulus(1'b1, mPred ^ 4'h3, 1'b1);
    checkOutput("clr_err0", 32'(err_count), 32'd0);
    checkOutput("clr_pulse", 32'(err_pulse), 32'd1);
    applyStimulus(1'b1, mPred, 1'b0);

    $display("[TB] saturation");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, mPred ^ 4'h6, 1'b0);
      applyStimulus(1'b1, mPred ^ 4'h9, 1'b0);
      applyStimulus(1'b1, mPred, 1'b0);
    end
    checkOutput("sat_stops15", 32'(s_err_count), 32'd15);
    checkOutput("wide_err20", 32'(err_count), 32'd20);
    checkOutput("sat_still_locked", 32'(locked), 32'd1);

    $display("[TB] period measurement");
    doReset();
    feedRun(4'd1, 5, 0);
    feedRun(4'd6, 40, 0);
    checkOutput("period_count_val", 32'(period_count), 32'(EXP_PC));
    checkOutput("period_ok_val", 32'(period_ok), 32'(EXP_POK));

    $display("[TB] random stream");
    for (int i = 0; i < 400; i++) begin
      logic       v;
      logic [3:0] s;
      logic       c;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : mPred;
      c = ($urandom_range(0, 40) == 0);
      applyStimulus(v, s, c);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
